// File: rtl/rx_frame_ctrl.sv
`timescale 1ns/1ps
// Serial-receive control: line sync, start detect, mid-bit shift strobes, stop check, valid/ack buffer.
// Build option: define RX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module rx_frame_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tx_data,
  output logic       rxd_sync,
  input  logic [7:0] shr,
  output logic       shift,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  // States: IDLE, START (half-bit check), DATA, PARITY (optional), STOP, WAIT_HI (line break)
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;
`ifdef RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_POST_DATA = S_PARITY;
`else
  localparam logic [2:0] S_POST_DATA = S_STOP;
`endif

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             deliver;
  logic             par_ok;
  logic             bit_tc;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= tx_data;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_sync = sync2_q;
  assign bit_tc   = (cnt_q == BIT_TC);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bitcnt_d    = bitcnt_q;
    shift       = 1'b0;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_sync) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = rxd_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tc) begin
          cnt_d    = '0;
          shift    = 1'b1;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_POST_DATA;
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (bit_tc) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tc) begin
          cnt_d = '0;
          if (rxd_sync) begin
            deliver = par_ok;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        cnt_d = '0;
        if (rxd_sync) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A completion on the same edge as an ack is a clean hand-over, not an overrun.
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (deliver) begin
      rx_byte_d  = shr;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;

  // Parity verdict is held until the stop sample so both errors report together.
  always_comb begin
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
    if (state_q == S_PARITY && bit_tc) par_bad_d = ^shr ^ rxd_sync;
    if (state_q == S_STOP && bit_tc)   parity_err_d = par_bad_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign par_ok     = ~par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
`timescale 1ns/1ps
// Directed bench for rx_frame_ctrl with a behavioural RX shift register on shr.
module tb_rx_frame_ctrl;
  localparam int CPB = 16;
`ifdef RX_PARITY_EN
  localparam int LAT = 3 + CPB/2 + 10*CPB;
`else
  localparam int LAT = 3 + CPB/2 + 9*CPB;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       tx_data = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] shr_m;
  logic       rxd_sync, shift, rx_valid, frame_err, parity_err, overrun, busy;
  logic [7:0] rx_byte;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int shift_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int gap_bad = 0;
  int last_shift = -1000;
  int rise_cyc = 0;
  int start_cyc = 0;
  int s0, f0, p0;
  logic rv_prev = 1'b0;
`ifdef RX_PARITY_EN
  logic flip_par = 1'b0;
`endif

  always #5 clk = ~clk;

  rx_frame_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .tx_data(tx_data), .rxd_sync(rxd_sync), .shr(shr_m),
    .shift(shift), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  // RX shift register, LSB first: the first data bit ends up in bit 0.
  always @(posedge clk or negedge clr) begin
    if (!clr) shr_m <= 8'h00;
    else if (shift) shr_m <= {rxd_sync, shr_m[7:1]};
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (shift) begin
      if ((cyc - last_shift) < 2*CPB && (cyc - last_shift) != CPB) gap_bad = gap_bad + 1;
      last_shift = cyc;
      shift_cnt  = shift_cnt + 1;
    end
    if (frame_err)  ferr_cnt = ferr_cnt + 1;
    if (parity_err) perr_cnt = perr_cnt + 1;
  end

  // Edge index of rx_valid rising, counted with the first edge sampling the start bit as 1.
  always @(negedge clk) begin
    if (rx_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc;
    tx_data = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx_data = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    tx_data = ^d ^ flip_par;
    repeat (CPB) @(negedge clk);
`endif
    tx_data = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rxd_sync", rxd_sync, 1'b1);
    chk("rst_shift", shift, 1'b0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    clr = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame, latency and handshake
    s0 = shift_cnt;
    send_frame(8'hA5, 1'b1);
    chk("a5_shifts", shift_cnt - s0, 8);
    chk("a5_gap", gap_bad, 0);
    chk("a5_byte", rx_byte, 8'hA5);
    chk("a5_valid", rx_valid, 1'b1);
    chk("a5_latency", rise_cyc - start_cyc, LAT);
    repeat (10) @(negedge clk);
    chk("a5_valid_hold", rx_valid, 1'b1);
    ack_pulse();
    chk("a5_valid_acked", rx_valid, 1'b0);
    chk("a5_byte_after_ack", rx_byte, 8'hA5);
    ack_pulse();
    @(negedge clk);
    chk("idle_ack_ignored", rx_valid, 1'b0);
    chk("idle_ack_overrun", overrun, 1'b0);

    // Short low glitch is rejected
    s0 = shift_cnt;
    tx_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy", busy, 1'b1);
    @(negedge clk);
    tx_data = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_shifts", shift_cnt - s0, 0);
    chk("glitch_idle", busy, 1'b0);
    chk("glitch_valid", rx_valid, 1'b0);

    // Bad stop bit, line held low (break)
    s0 = shift_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    chk("ferr_pulses", ferr_cnt - f0, 1);
    chk("ferr_valid", rx_valid, 1'b0);
    chk("ferr_wait_hi", busy, 1'b1);
    chk("ferr_shifts", shift_cnt - s0, 8);
    tx_data = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr_released", busy, 1'b0);
    chk("ferr_pulses_after", ferr_cnt - f0, 1);

    // Overrun: two back-to-back frames, no ack
    send_frame(8'h11, 1'b1);
    chk("ovr_first_valid", rx_valid, 1'b1);
    chk("ovr_first_flag", overrun, 1'b0);
    send_frame(8'h22, 1'b1);
    chk("ovr_byte", rx_byte, 8'h22);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    repeat (5) @(negedge clk);
    chk("ovr_sticky", overrun, 1'b1);
    clr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared_by_clr", overrun, 1'b0);
    clr = 1'b1;
    repeat (5) @(negedge clk);

    // Ack lands on the completion edge of the second frame
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        ack_pulse();
      end
    join
    chk("ack_edge_byte", rx_byte, 8'h22);
    chk("ack_edge_valid", rx_valid, 1'b1);
    chk("ack_edge_overrun", overrun, 1'b0);

    // Reset after the third shift of a frame
    s0 = shift_cnt;
    tx_data = 1'b0;
    repeat (CPB) @(negedge clk);
    tx_data = 1'b1;
    repeat (2*CPB) @(negedge clk);
    tx_data = 1'b0;
    repeat (CPB) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("mid_shifts", shift_cnt - s0, 3);
    chk("mid_busy", busy, 1'b1);
    clr = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_byte", rx_byte, 8'h00);
    chk("mid_rst_rxd_sync", rxd_sync, 1'b1);
    chk("mid_rst_shift", shift, 1'b0);
    chk("mid_rst_shr", shr_m, 8'h00);
    tx_data = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_post_idle", busy, 1'b0);
    f0 = ferr_cnt;
    p0 = perr_cnt;
    send_frame(8'h5A, 1'b1);
    chk("5a_byte", rx_byte, 8'h5A);
    chk("5a_valid", rx_valid, 1'b1);
    chk("5a_ferr", ferr_cnt - f0, 0);
    chk("5a_perr", perr_cnt - p0, 0);
    chk("5a_overrun", overrun, 1'b0);
    ack_pulse();
    chk("5a_acked", rx_valid, 1'b0);

`ifdef RX_PARITY_EN
    // 0x07 has odd weight: parity bit 0 is wrong, 1 is right
    f0 = ferr_cnt;
    p0 = perr_cnt;
    flip_par = 1'b1;
    send_frame(8'h07, 1'b1);
    chk("par_bad_pulse", perr_cnt - p0, 1);
    chk("par_bad_valid", rx_valid, 1'b0);
    chk("par_bad_ferr", ferr_cnt - f0, 0);
    repeat (4) @(negedge clk);
    chk("par_bad_idle", busy, 1'b0);
    p0 = perr_cnt;
    flip_par = 1'b0;
    send_frame(8'h07, 1'b1);
    chk("par_ok_byte", rx_byte, 8'h07);
    chk("par_ok_valid", rx_valid, 1'b1);
    chk("par_ok_perr", perr_cnt - p0, 0);
    chk("par_ok_latency", rise_cyc - start_cyc, LAT);
`else
    chk("parity_err_never", perr_cnt, 0);
`endif

    chk("gap_total", gap_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
